// File: rtl/audio_nios_i2c_pkg.sv
// Shared definitions for the Avalon-MM byte-level I2C master: register map,
// command/status bit positions, FSM and quarter-bit encodings.
package audio_nios_i2c_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CLKDIV = 2'd3;

  localparam int CMD_START  = 0;
  localparam int CMD_STOP   = 1;
  localparam int CMD_WR     = 2;
  localparam int CMD_RD     = 3;
  localparam int CMD_NACK   = 4;
  localparam int CMD_IRQ_EN = 5;

  // Nine bits per byte: 0..7 data, 8 acknowledge.
  localparam logic [3:0] ACK_BIT = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  typedef struct packed {
    logic stop;
    logic wr;
    logic rd;
    logic nack;
  } cmd_t;

endpackage

// File: rtl/audio_nios_i2c_qtick.sv
// Quarter-bit tick generator: one qtick every CLKDIV+1 clocks while enabled;
// the tick is withheld while hold is high so a stretched quarter does not end.
module audio_nios_i2c_qtick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             hold,
  input  logic [DIV_W-1:0] clkdiv,
  output logic             qtick
);

  logic [DIV_W-1:0] cnt;

  assign qtick = en && !hold && (cnt == '0);

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= clkdiv;
    end else if (cnt == '0) begin
      if (!hold) cnt <= clkdiv;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/audio_nios_i2c_master.sv
// Avalon-MM byte-level I2C master for the audio codec: register file, phase FSM
// (START / 9-bit byte / STOP), shift registers and open-drain SCL/SDA drivers.
module audio_nios_i2c_master
  import audio_nios_i2c_pkg::*;
#(
  parameter int unsigned CLKDIV_RESET = 124,
  parameter int          DIV_W        = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  inout  wire         i2c_scl,
  inout  wire         i2c_sda
);

  state_t           state, state_d;
  quarter_t         q, q_d;
  logic [3:0]       bit_cnt, bit_d;
  logic [2:0]       bit_idx;
  logic             scl_oe, scl_oe_d, sda_oe, sda_oe_d;
  logic             scl_meta, scl_sync, sda_meta, sda_sync;
  logic [7:0]       data_q, rx_q;
  logic [DIV_W-1:0] clkdiv_q;
  logic             irq_en, done, rx_nack;
  cmd_t             cmd_q, cmd_eff;
  logic             busy, wr_en, cmd_wr, go, hold, qtick, enter;

  wire unused_wd = ^writedata[31:DIV_W];

  assign wr_en  = chipselect && !write_n;
  assign busy   = (state != S_IDLE);
  assign cmd_wr = wr_en && (address == ADDR_CMD) && !busy;
  assign go     = cmd_wr && (|writedata[CMD_RD:CMD_START]);
  // A released SCL still read low means a slave is stretching the clock.
  assign hold   = !scl_oe && !scl_sync;
  assign enter  = go || (busy && qtick);
  assign irq    = done && irq_en;

  assign i2c_scl = scl_oe ? 1'b0 : 1'bz;
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  audio_nios_i2c_qtick #(.DIV_W(DIV_W)) u_qtick (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (busy),
    .hold   (hold),
    .clkdiv (clkdiv_q),
    .qtick  (qtick)
  );

  always_comb begin
    cmd_eff = cmd_q;
    if (go) begin
      cmd_eff.stop = writedata[CMD_STOP];
      cmd_eff.wr   = writedata[CMD_WR];
      cmd_eff.rd   = writedata[CMD_RD];
      cmd_eff.nack = writedata[CMD_NACK];
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    state_d  = state;
    q_d      = q;
    bit_d    = bit_cnt;
    scl_oe_d = scl_oe;
    sda_oe_d = sda_oe;
    if (state == S_IDLE) begin
      if (go) begin
        q_d   = Q0;
        bit_d = '0;
        if (writedata[CMD_START])                   state_d = S_START;
        else if (writedata[CMD_WR] || writedata[CMD_RD]) state_d = S_BIT;
        else                                        state_d = S_STOP;
      end
    end else if (qtick) begin
      q_d = quarter_t'(q + 2'd1);
      if (q == Q3) begin
        case (state)
          S_START: begin
            bit_d   = '0;
            state_d = (cmd_eff.wr || cmd_eff.rd) ? S_BIT :
                      cmd_eff.stop ? S_STOP : S_IDLE;
          end
          S_BIT: begin
            if (bit_cnt == ACK_BIT) state_d = cmd_eff.stop ? S_STOP : S_IDLE;
            else                    bit_d   = bit_cnt + 4'd1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
    bit_idx = 3'd7 - bit_d[2:0];
    // Pin drives are set on entry to each quarter; "1" pulls the line low.
    if (enter) begin
      case (state_d)
        S_START: begin
          case (q_d)
            Q0:      begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
            Q1:      sda_oe_d = 1'b1;
            Q2:      scl_oe_d = 1'b1;
            default: ;
          endcase
        end
        S_BIT: begin
          case (q_d)
            Q0: begin
              scl_oe_d = 1'b1;
              if (bit_d == ACK_BIT) sda_oe_d = cmd_eff.wr ? 1'b0 : !cmd_eff.nack;
              else                  sda_oe_d = cmd_eff.wr ? !data_q[bit_idx] : 1'b0;
            end
            Q1:      scl_oe_d = 1'b0;
            Q3:      scl_oe_d = 1'b1;
            default: ;
          endcase
        end
        S_STOP: begin
          case (q_d)
            Q0:      begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
            Q1:      scl_oe_d = 1'b0;
            Q2:      sda_oe_d = 1'b0;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      q        <= Q0;
      bit_cnt  <= '0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      data_q   <= '0;
      rx_q     <= '0;
      clkdiv_q <= DIV_W'(CLKDIV_RESET);
      irq_en   <= 1'b0;
      done     <= 1'b0;
      rx_nack  <= 1'b0;
      cmd_q    <= '0;
      readdata <= '0;
    end else begin
      state    <= state_d;
      q        <= q_d;
      bit_cnt  <= bit_d;
      scl_oe   <= scl_oe_d;
      sda_oe   <= sda_oe_d;
      scl_meta <= i2c_scl;
      scl_sync <= scl_meta;
      sda_meta <= i2c_sda;
      sda_sync <= sda_meta;

      if (cmd_wr) irq_en  <= writedata[CMD_IRQ_EN];
      if (go)     cmd_q   <= cmd_eff;
      if (wr_en && (address == ADDR_CLKDIV) && !busy) clkdiv_q <= writedata[DIV_W-1:0];

      if (busy && qtick && (state == S_BIT) && (q == Q2)) begin
        if (cmd_q.wr) begin
          if (bit_cnt == ACK_BIT) rx_nack <= sda_sync;
        end else if (bit_cnt != ACK_BIT) begin
          rx_q <= {rx_q[6:0], sda_sync};
        end
      end

      if (busy && qtick && (state == S_BIT) && (q == Q3) && (bit_cnt == ACK_BIT) && !cmd_q.wr)
        data_q <= rx_q;
      else if (wr_en && (address == ADDR_DATA) && !busy)
        data_q <= writedata[7:0];

      if (busy && (state_d == S_IDLE))                done <= 1'b1;
      else if (wr_en && (address == ADDR_STATUS))     done <= 1'b0;

      case (address)
        ADDR_DATA:   readdata <= 32'(data_q);
        ADDR_STATUS: readdata <= {29'd0, done, rx_nack, busy};
        ADDR_CLKDIV: readdata <= 32'(clkdiv_q);
        default:     readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_nios_i2c_master.sv
// Directed bench for audio_nios_i2c_master: an I2C slave model on pulled-up lines,
// a bus monitor checked against a queue of expected START/byte/STOP events.
module tb_audio_nios_i2c_master;
  import audio_nios_i2c_pkg::*;

  localparam logic [31:0] EV_START = 32'h1000;
  localparam logic [31:0] EV_STOP  = 32'h2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  wire         scl_w, sda_w;

  pullup (scl_w);
  pullup (sda_w);

  logic       slv_scl_low = 1'b0, slv_sda_low = 1'b0;
  logic       slv_tx = 1'b0, slv_ack = 1'b1, stretch_req = 1'b0;
  logic [7:0] slv_byte = '0;
  int         stretch_cnt = 0;
  assign scl_w = slv_scl_low ? 1'b0 : 1'bz;
  assign sda_w = slv_sda_low ? 1'b0 : 1'bz;

  int          checks = 0, errors = 0, cyc = 0;
  int          gap_min = 1000000, gap_max = 0;
  logic [31:0] exp_bus[$];
  logic [31:0] exp_rd[$];

  audio_nios_i2c_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .i2c_scl   (scl_w),
    .i2c_sda   (sda_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_event(input logic [31:0] ev);
    if (exp_bus.size() == 0) check("bus_extra_event", ev, 32'hFFFF_FFFF);
    else                     check("bus_event", ev, exp_bus.pop_front());
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    exp_rd.push_back(exp);
    rd(a, v);
    check(tag, v, exp_rd.pop_front());
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    do begin
      rd(ADDR_STATUS, s);
      n++;
    end while (s[0] && n < 2000);
    check({tag, "_idle"}, 32'(s[0]), 32'd0);
    check({tag, "_bus_all_seen"}, 32'(exp_bus.size()), 32'd0);
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic ack);
    exp_bus.push_back(32'({b, ack}));
  endtask

  // Bus monitor: START/STOP while SCL high, one bit per SCL rise, frames of 9.
  initial begin : monitor
    logic ps, pd;
    logic [8:0] sh;
    int nbits, last_rise, gap;
    ps = 1'b1; pd = 1'b1; sh = '0; nbits = 0; last_rise = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (ps && scl_w && pd && !sda_w) begin
          bus_event(EV_START); nbits = 0;
        end else if (ps && scl_w && !pd && sda_w) begin
          bus_event(EV_STOP); nbits = 0;
        end else if (!ps && scl_w) begin
          if (nbits >= 1) begin
            gap = cyc - last_rise;
            if (gap < gap_min) gap_min = gap;
            if (gap > gap_max) gap_max = gap;
          end
          last_rise = cyc;
          sh = {sh[7:0], sda_w};
          nbits++;
          if (nbits == 9) begin
            bus_event(32'(sh)); nbits = 0;
          end
        end
      end
      ps = scl_w; pd = sda_w;
    end
  end

  // Slave model: changes SDA only after SCL falls; receives or transmits one byte.
  initial begin : slave
    logic ps, pd;
    int rises;
    ps = 1'b1; pd = 1'b1; rises = 0;
    forever begin
      @(negedge clk);
      if (stretch_cnt > 0) begin
        stretch_cnt--;
        if (stretch_cnt == 0) slv_scl_low = 1'b0;
      end
      if (ps && scl_w && (pd != sda_w)) begin
        rises = 0;
        if (sda_w) slv_sda_low = 1'b0;
      end else if (!ps && scl_w) begin
        rises++;
      end else if (ps && !scl_w) begin
        if (slv_tx) slv_sda_low = (rises < 8) ? !slv_byte[7 - rises] : 1'b0;
        else        slv_sda_low = (rises == 8) ? slv_ack : 1'b0;
        if (stretch_req && rises == 3) begin
          slv_scl_low = 1'b1; stretch_cnt = 60; stretch_req = 1'b0;
        end
      end
      ps = scl_w; pd = sda_w;
    end
  end

  initial begin : stimulus
    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_scl_released", 32'(scl_w), 32'd1);
    reset_n = 1'b1;
    chk_reg("rst_data", ADDR_DATA, 32'h0);
    chk_reg("rst_status", ADDR_STATUS, 32'h0);
    chk_reg("rst_clkdiv", ADDR_CLKDIV, 32'd124);
    chk_reg("rst_cmd_reads_0", ADDR_CMD, 32'h0);
    check("rst_sda_released", 32'(sda_w), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);

    // 2: write 0xA5, slave ACKs
    wr(ADDR_CLKDIV, 32'd3);
    wr(ADDR_DATA, 32'hA5);
    slv_tx = 1'b0; slv_ack = 1'b1;
    exp_bus.push_back(EV_START); expect_frame(8'hA5, 1'b0); exp_bus.push_back(EV_STOP);
    gap_min = 1000000; gap_max = 0;
    wr(ADDR_CMD, 32'h07);
    chk_reg("t2_busy", ADDR_STATUS, 32'h1);
    wait_idle("t2");
    chk_reg("t2_status_done", ADDR_STATUS, 32'h4);
    check("t2_scl_period_min", 32'(gap_min), 32'd16);
    check("t2_scl_period_max", 32'(gap_max), 32'd16);
    check("t2_irq_disabled", 32'(irq), 32'd0);

    // 3: slave NACKs, STOP still generated
    wr(ADDR_STATUS, 32'h0);
    chk_reg("t3_done_cleared", ADDR_STATUS, 32'h0);
    slv_ack = 1'b0;
    exp_bus.push_back(EV_START); expect_frame(8'hA5, 1'b1); exp_bus.push_back(EV_STOP);
    wr(ADDR_CMD, 32'h07);
    wait_idle("t3");
    chk_reg("t3_status_nack", ADDR_STATUS, 32'h6);

    // 4: read 0x3C with master NACK
    wr(ADDR_STATUS, 32'h0);
    slv_tx = 1'b1; slv_byte = 8'h3C;
    expect_frame(8'h3C, 1'b1); exp_bus.push_back(EV_STOP);
    wr(ADDR_CMD, 32'h1A);
    wait_idle("t4");
    chk_reg("t4_rx_data", ADDR_DATA, 32'h3C);
    chk_reg("t4_status", ADDR_STATUS, 32'h6);

    // 5: clock stretching in bit 3
    wr(ADDR_STATUS, 32'h0);
    slv_tx = 1'b0; slv_ack = 1'b1; stretch_req = 1'b1;
    wr(ADDR_DATA, 32'hC3);
    exp_bus.push_back(EV_START); expect_frame(8'hC3, 1'b0); exp_bus.push_back(EV_STOP);
    gap_min = 1000000; gap_max = 0;
    wr(ADDR_CMD, 32'h07);
    wait_idle("t5");
    check("t5_bit_stretched", 32'(gap_max >= 66), 32'd1);
    chk_reg("t5_status", ADDR_STATUS, 32'h4);
    chk_reg("t5_data", ADDR_DATA, 32'hC3);

    // 6: writes while busy ignored; irq gating
    wr(ADDR_STATUS, 32'h0);
    wr(ADDR_DATA, 32'h5A);
    exp_bus.push_back(EV_START); expect_frame(8'h5A, 1'b0); exp_bus.push_back(EV_STOP);
    gap_min = 1000000; gap_max = 0;
    wr(ADDR_CMD, 32'h07);
    repeat (40) @(negedge clk);
    chk_reg("t6_busy", ADDR_STATUS, 32'h1);
    wr(ADDR_CMD, 32'h28);
    wr(ADDR_CLKDIV, 32'd100);
    wr(ADDR_DATA, 32'hFF);
    wait_idle("t6");
    chk_reg("t6_clkdiv_kept", ADDR_CLKDIV, 32'd3);
    chk_reg("t6_data_kept", ADDR_DATA, 32'h5A);
    check("t6_period_min", 32'(gap_min), 32'd16);
    check("t6_period_max", 32'(gap_max), 32'd16);
    check("t6_irq_off_when_disabled", 32'(irq), 32'd0);
    wr(ADDR_CMD, 32'h20);
    @(negedge clk);
    check("t6_irq_en_only_cmd", 32'(irq), 32'd1);
    wr(ADDR_STATUS, 32'h0);
    @(negedge clk);
    check("t6_irq_cleared", 32'(irq), 32'd0);
    exp_bus.push_back(EV_STOP);
    wr(ADDR_CMD, 32'h22);
    repeat (5) @(negedge clk);
    check("t6_irq_low_while_busy", 32'(irq), 32'd0);
    wait_idle("t6_stop");
    check("t6_irq_with_done", 32'(irq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
